spi_master_ctrl: RTL and testbench
==================================

// Module: spi_master_ctrl
// PURPOSE
//  Host-side SPI master that sequences complete read/write transactions to the SPI memory (the fsm-controlled slave).
//  Accepts one request at a time from a host (req/ready), generates cs/sclk/mosi, captures miso on reads.
//  Frame: 7 addr bits MSB-first, 1 R/W bit (1=read, 0=write), then 8 data bits. 16 sclk periods total.
// PARAMETERS
//  CLK_DIV  4  clk cycles per sclk half-period; legal range >=2
//  CS_GAP   2  sclk half-periods cs held high after a frame before the next accept
//  ADDR_W   7  address bits per frame (fixed by memory protocol)
//  DATA_W   8  data bits per frame
// PORTS
//  clk          in   1       system clock; all logic on posedge
//  reset        in   1       synchronous, active-high
//  req          in   1       host request; accepted when req && ready
//  ready        out  1       1 only in IDLE and reset deasserted
//  rw           in   1       1=read, 0=write; sampled at accept
//  addr         in   ADDR_W  target address; sampled at accept
//  wdata        in   DATA_W  write data; sampled at accept
//  rdata        out  DATA_W  read data; valid from done, held until next read's done
//  done         out  1       one-cycle pulse at end of frame
//  busy         out  1       1 from cycle after accept until return to IDLE
//  cs           out  1       SPI chip select, active-low
//  sclk         out  1       SPI clock, idles low
//  mosi         out  1       SPI data to memory
//  miso         in   1       SPI data from memory
// BEHAVIOUR
//  Reset (sync, any state): next edge -> IDLE; cs=1, sclk=0, mosi=0, done=0, busy=0, rdata=0; ready=0 while reset=1.
//  Reset mid-frame: cs rises on next edge, no done pulse, rdata unchanged from its reset value (0).
//  States: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
//   IDLE: ready=1. On req: latch shreg={addr,rw,(rw?0:wdata)}, go SETUP. req when !ready is ignored (no queue).
//   SETUP: cs=0, mosi=shreg[15], sclk=0 for one half-period.
//   SHIFT: 32 half-periods; sclk toggles at each half-period tick; bit counter 0..15.
//     sclk 0->1 edge: slave samples mosi. sclk 1->0 edge: shreg shifts left, mosi=next bit;
//     if rw=1 and bit index 8..15, miso shifted into rx reg on the same clk edge.
//   HOLD: after 16th falling edge, one half-period with cs=0, sclk=0.
//   GAP: cs=1, done pulses in first GAP cycle (rdata updated same edge if read), lasts CS_GAP half-periods.
//  Timing (accept at cycle T, CLK_DIV=D): cs=0 from T+1; sclk rises at T+1+(2k+1)D, falls at T+1+(2k+2)D, k=0..15;
//   done and cs=1 at T+1+33D; ready=1 again at T+1+33D+CS_GAP*D. D=4, CS_GAP=2: done at T+133, ready at T+141.
//  Half-period tick: divider counts 0..CLK_DIV-1, cleared on accept and reset; tick on terminal count.
//  Write frames: miso ignored, rdata unchanged. Read frames: mosi=0 during data bits.
//  addr/wdata/rw changes after accept have no effect on the frame in flight.
//  req held high continuously: next accept on first cycle ready=1; back-to-back frames separated by exactly CS_GAP*D clk with cs=1.
// STRUCTURE
//  spi_defs.vh: state encodings, FRAME_BITS=16, RW_READ=1'b1, RW_WRITE=1'b0 (shared with fsm testbenches).
//  Sub-module spi_clk_div: parameter CLK_DIV; inputs clk, reset, clear; output tick. Everything else in spi_master_ctrl.
// TESTING
//  Bench: spi_master_ctrl driving the SPI memory (fsm + datapath); also a passive mosi/sclk monitor.
//  1 write addr=0x2A wdata=0xA5 -> monitor sees bytes 0x54,0xA5 on sclk rises; done at T+133 (D=4).
//  2 read addr=0x2A after test 1 -> mosi bytes 0x55,0x00; rdata=0xA5 at done; cs=1 same cycle.
//  3 req held high, write 0x01<-0x3C then read 0x01 -> second accept exactly 8 clk after first done; rdata=0x3C.
//  4 reset asserted at T+60 of a write -> next cycle cs=1, sclk=0, busy=0, no done; ready=1 after reset drops.
//  5 changing addr/wdata/rw every cycle after accept -> frame bits match values latched at accept.
//  6 req asserted while busy=1 -> ignored; no second frame starts until ready=1 and req sampled again.

Source files
------------

// File: rtl/spi_master_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_master_ctrl_pkg
// Brief    : Shared frame constants and state encoding for the SPI master
// Revision : 1.0 - initial release
// ============================================================================
package spi_master_ctrl_pkg;

  // 7 address bits, 1 R/W bit, 8 data bits
  localparam int FRAME_BITS = 16;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/spi_clk_div.sv
`default_nettype none
// ============================================================================
// Module   : spi_clk_div
// Brief    : Half-period tick generator; counts 0..CLK_DIV-1, ticks on the
//            terminal count, restartable so a frame starts phase-aligned
// Revision : 1.0 - initial release
// ============================================================================
module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = $clog2(CLK_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CNT_W'(CLK_DIV - 1));

  // Next count: clear has priority so the first half-period after accept is full length
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : spi_master_ctrl
// Brief    : Host-side SPI master running one 16-bit read/write frame per
//            accepted request (addr, R/W, data; MSB first)
// Revision : 1.0 - initial release
// ============================================================================
module spi_master_ctrl
  import spi_master_ctrl_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 2,
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  output logic              ready,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              done,
  output logic              busy,
  output logic              cs,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso
);

  localparam int FRAME_W        = FRAME_BITS;
  localparam int BIT_W          = $clog2(FRAME_W);
  localparam int GAP_W          = $clog2(CS_GAP + 1);
  localparam int FIRST_DATA_BIT = ADDR_W + 1;

  state_e             state_q, state_d;
  logic [FRAME_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0]  rx_q, rx_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               rw_q, rw_d;
  logic               sclk_q, sclk_d;
  logic               mosi_q, mosi_d;
  logic               done_q, done_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               tick;
  logic               accept;

  assign ready  = (state_q == ST_IDLE) && !reset;
  assign accept = req && ready;
  assign busy   = (state_q != ST_IDLE);
  assign cs     = !((state_q == ST_SETUP) || (state_q == ST_SHIFT) || (state_q == ST_HOLD));
  assign sclk   = sclk_q;
  assign mosi   = mosi_q;
  assign done   = done_q;
  assign rdata  = rdata_q;

  spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk   (clk),
    .reset (reset),
    .clear (accept),
    .tick  (tick)
  );

  // Frame sequencer: state transitions, sclk/mosi generation and miso capture
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    rx_d    = rx_q;
    rdata_d = rdata_q;
    rw_d    = rw_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    done_d  = 1'b0;
    bit_d   = bit_q;
    gap_d   = gap_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          // Read frames carry zeros in the data slot
          shreg_d = {addr, rw, (rw == RW_WRITE) ? wdata : {DATA_W{1'b0}}};
          rw_d    = rw;
          mosi_d  = shreg_d[FRAME_W-1];
          sclk_d  = 1'b0;
          bit_d   = '0;
          gap_d   = '0;
          state_d = ST_SETUP;
        end
      end

      ST_SETUP: begin
        if (tick) begin
          sclk_d  = 1'b1;
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (tick) begin
          if (sclk_q) begin
            // Falling edge: present the next bit and capture the data-phase miso
            sclk_d  = 1'b0;
            shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
            mosi_d  = shreg_q[FRAME_W-2];
            if ((rw_q == RW_READ) && (bit_q >= BIT_W'(FIRST_DATA_BIT))) begin
              rx_d = {rx_q[DATA_W-2:0], miso};
            end
            if (bit_q == BIT_W'(FRAME_W - 1)) begin
              mosi_d  = 1'b0;
              state_d = ST_HOLD;
            end else begin
              bit_d = bit_q + BIT_W'(1);
            end
          end else begin
            sclk_d = 1'b1;
          end
        end
      end

      ST_HOLD: begin
        if (tick) begin
          done_d  = 1'b1;
          gap_d   = '0;
          state_d = ST_GAP;
          if (rw_q == RW_READ) begin
            rdata_d = rx_q;
          end
        end
      end

      ST_GAP: begin
        if (tick) begin
          if (gap_q == GAP_W'(CS_GAP - 1)) begin
            state_d = ST_IDLE;
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset returns to an idle, deselected bus
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      rx_q    <= '0;
      rdata_q <= '0;
      rw_q    <= 1'b0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      done_q  <= 1'b0;
      bit_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
      rw_q    <= rw_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      done_q  <= done_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_master_ctrl
// Brief    : Scoreboard bench for spi_master_ctrl with a behavioural SPI
//            memory slave; frames and done events checked against queues
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_master_ctrl;
  import spi_master_ctrl_pkg::*;

  localparam int D        = 4;
  localparam int DONE_LAT = 133;  // 1 + 33*D
  localparam int B2B_LAT  = 141;  // 1 + 35*D

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req = 1'b0;
  logic       ready;
  logic       rw = 1'b0;
  logic [6:0] addr = '0;
  logic [7:0] wdata = '0;
  logic [7:0] rdata;
  logic       done;
  logic       busy;
  logic       cs;
  logic       sclk;
  logic       mosi;
  logic       miso = 1'b0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int         cyc;
    logic       is_rd;
    logic [7:0] rdata;
  } done_exp_t;

  done_exp_t   done_q[$];
  logic [15:0] frame_q[$];
  logic [7:0]  mem [128];

  spi_master_ctrl #(
    .CLK_DIV (D),
    .CS_GAP  (2),
    .ADDR_W  (7),
    .DATA_W  (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .ready (ready),
    .rw    (rw),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .done  (done),
    .busy  (busy),
    .cs    (cs),
    .sclk  (sclk),
    .mosi  (mosi),
    .miso  (miso)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural SPI memory: samples mosi on sclk rises, drives miso for read data
  initial begin : slave
    logic        sclk_prev;
    int          bitn;
    int          k;
    logic [15:0] fr;
    logic [6:0]  f_addr;
    logic        f_rw;
    logic [7:0]  rd_byte;
    logic [15:0] exp_fr;
    sclk_prev = 1'b0;
    bitn      = 0;
    fr        = '0;
    f_addr    = '0;
    f_rw      = 1'b0;
    rd_byte   = '0;
    forever begin
      @(negedge clk);
      if (cs === 1'b1) begin
        bitn = 0;
        miso = 1'b0;
      end else if (cs === 1'b0 && sclk === 1'b1 && sclk_prev === 1'b0) begin
        fr = {fr[14:0], mosi};
        k  = bitn;
        bitn++;
        if (k == 7) begin
          f_addr  = fr[7:1];
          f_rw    = fr[0];
          rd_byte = mem[f_addr];
        end
        if (k >= 8 && f_rw) miso = rd_byte[15-k];
        if (bitn == FRAME_BITS) begin
          bitn = 0;
          if (frame_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_frame: got 0x%0h expected none", fr);
          end else begin
            exp_fr = frame_q.pop_front();
            check("frame_bits", {16'h0, fr}, {16'h0, exp_fr});
          end
          if (!f_rw) mem[f_addr] = fr[7:0];
        end
      end
      sclk_prev = sclk;
    end
  end

  // Done monitor: timing, chip-select state and read data at each done pulse
  initial begin : done_mon
    done_exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (done_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
        end else begin
          e = done_q.pop_front();
          check("done_cycle", cyc, e.cyc);
          check("cs_at_done", {31'h0, cs}, 32'h1);
          if (e.is_rd) check("rdata_at_done", {24'h0, rdata}, {24'h0, e.rdata});
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (ready !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (ready !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: got ready=%b expected 1", ready);
    end
  endtask

  // Issue one request; expectations go to the scoreboard before the frame runs
  task automatic issue(input logic i_rw, input logic [6:0] i_addr, input logic [7:0] i_wdata,
                       input logic [15:0] exp_frame, input logic [7:0] exp_rd);
    done_exp_t e;
    wait_ready();
    rw    = i_rw;
    addr  = i_addr;
    wdata = i_wdata;
    req   = 1'b1;
    e.cyc = cyc + DONE_LAT;
    e.is_rd = i_rw;
    e.rdata = exp_rd;
    frame_q.push_back(exp_frame);
    done_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int        t;
    done_exp_t e;
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cs", {31'h0, cs}, 32'h1);
    check("rst_sclk", {31'h0, sclk}, 32'h0);
    check("rst_mosi", {31'h0, mosi}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_rdata", {24'h0, rdata}, 32'h0);
    check("rst_ready", {31'h0, ready}, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_rst", {31'h0, ready}, 32'h1);

    // 1: write 0x2A <- 0xA5
    issue(RW_WRITE, 7'h2A, 8'hA5, 16'h54A5, 8'h00);
    check("cs_low_after_accept", {31'h0, cs}, 32'h0);
    check("busy_after_accept", {31'h0, busy}, 32'h1);
    check("ready_low_busy", {31'h0, ready}, 32'h0);

    // 2: read back 0x2A
    issue(RW_READ, 7'h2A, 8'hFF, 16'h5500, 8'hA5);

    // 3: req held high across two frames
    wait_ready();
    rw = RW_WRITE; addr = 7'h01; wdata = 8'h3C; req = 1'b1;
    t = cyc;
    frame_q.push_back(16'h023C);
    e.cyc = t + DONE_LAT; e.is_rd = 1'b0; e.rdata = 8'h00; done_q.push_back(e);
    frame_q.push_back(16'h0300);
    e.cyc = t + B2B_LAT + DONE_LAT; e.is_rd = 1'b1; e.rdata = 8'h3C; done_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    rw = RW_READ; wdata = 8'hFF;
    wait_ready();
    check("b2b_accept_cycle", cyc, t + B2B_LAT);
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;

    // 4: reset 60 cycles into a write frame
    wait_ready();
    rw = RW_WRITE; addr = 7'h10; wdata = 8'h77; req = 1'b1;
    t = cyc;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    while (cyc < t + 60) @(negedge clk);
    reset = 1'b1;
    #1;
    check("ready_in_reset", {31'h0, ready}, 32'h0);
    @(negedge clk);
    check("midrst_cs", {31'h0, cs}, 32'h1);
    check("midrst_sclk", {31'h0, sclk}, 32'h0);
    check("midrst_busy", {31'h0, busy}, 32'h0);
    check("midrst_rdata", {24'h0, rdata}, 32'h0);
    reset = 1'b0;
    #1;
    check("ready_after_midrst", {31'h0, ready}, 32'h1);

    // 5: inputs change every cycle after accept
    issue(RW_WRITE, 7'h15, 8'h5A, 16'h2A5A, 8'h00);
    for (int i = 0; i < 140; i++) begin
      addr  = 7'(i * 13);
      wdata = 8'(i * 7 + 1);
      rw    = i[0];
      @(negedge clk);
    end
    wait_ready();
    check("rdata_hold_write", {24'h0, rdata}, 32'h0);
    issue(RW_READ, 7'h15, 8'h00, 16'h2B00, 8'h5A);

    // 6: request while busy is dropped
    issue(RW_WRITE, 7'h33, 8'hC3, 16'h66C3, 8'h00);
    repeat (20) @(negedge clk);
    check("busy_mid_frame", {31'h0, busy}, 32'h1);
    rw = RW_WRITE; addr = 7'h44; wdata = 8'h11; req = 1'b1;
    repeat (3) @(negedge clk);
    req = 1'b0;
    wait_ready();
    repeat (30) @(negedge clk);
    check("idle_after_ignored_req", {31'h0, busy}, 32'h0);
    check("rdata_after_write", {24'h0, rdata}, 32'h5A);

    check("frames_outstanding", frame_q.size(), 32'h0);
    check("dones_outstanding", done_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
